// File: rtl/cla_pkg.sv
// rtl/cla_pkg.sv - shared FSM states, nibble width and width legality check for cla_seq_adder
package cla_pkg;

    localparam int NIB_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } cla_state_t;

    function automatic bit width_ok(input int w);
        return ((w % NIB_W) == 0) && (w >= 2 * NIB_W);
    endfunction

endpackage

// File: rtl/cla_slice4.sv
// rtl/cla_slice4.sv - combinational 4-bit carry-lookahead adder slice
module cla_slice4 (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    input  logic       i_cin,
    output logic [3:0] o_f,
    output logic       o_cout
);

    logic [3:0] w_g;
    logic [3:0] w_p;
    logic       w_c1;
    logic       w_c2;
    logic       w_c3;

    assign w_g = i_a & i_b;
    assign w_p = i_a ^ i_b;

    // Every carry is a flat function of g/p and cin; no ripple inside the slice.
    assign w_c1 = w_g[0] | (w_p[0] & i_cin);
    assign w_c2 = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & i_cin);
    assign w_c3 = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & i_cin);
    assign o_cout = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                  | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                  | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & i_cin);

    assign o_f = w_p ^ {w_c3, w_c2, w_c1, i_cin};

endmodule

// File: rtl/cla_seq_adder.sv
// rtl/cla_seq_adder.sv - nibble-serial wide adder over one shared CLA slice; CLA_SEQ_SUB_EN adds op (subtract)
module cla_seq_adder
    import cla_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef CLA_SEQ_SUB_EN
    input  logic             op,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);

    localparam int NIB   = WIDTH / NIB_W;
    localparam int IDX_W = $clog2(NIB);

    generate
        if (!width_ok(WIDTH)) begin : g_bad_width
            $error("cla_seq_adder: WIDTH must be a multiple of 4 and at least 8");
        end
    endgenerate

    cla_state_t       r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_carry;
    logic [IDX_W-1:0] r_idx;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;
    logic             r_in_ready;
    logic             r_out_valid;
    logic             r_busy;

    logic [WIDTH-1:0] w_b_cap;
    logic             w_cin_cap;
    logic [3:0]       w_a_nib;
    logic [3:0]       w_b_nib;
    logic [3:0]       w_f;
    logic             w_c;
    logic             w_last;

`ifdef CLA_SEQ_SUB_EN
    // Subtract is a + ~b + 1: invert B once at capture and seed the carry.
    assign w_b_cap   = op ? ~b : b;
    assign w_cin_cap = op ? 1'b1 : cin;
`else
    assign w_b_cap   = b;
    assign w_cin_cap = cin;
`endif

    assign w_a_nib = r_a[int'(r_idx) * NIB_W +: NIB_W];
    assign w_b_nib = r_b[int'(r_idx) * NIB_W +: NIB_W];
    assign w_last  = (r_idx == IDX_W'(NIB - 1));

    cla_slice4 u_slice (
        .i_a    (w_a_nib),
        .i_b    (w_b_nib),
        .i_cin  (r_carry),
        .o_f    (w_f),
        .o_cout (w_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_carry     <= 1'b0;
            r_idx       <= '0;
            r_sum       <= '0;
            r_cout      <= 1'b0;
            r_ovf       <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_a        <= a;
                        r_b        <= w_b_cap;
                        r_carry    <= w_cin_cap;
                        r_idx      <= '0;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_sum[int'(r_idx) * NIB_W +: NIB_W] <= w_f;
                    r_carry <= w_c;
                    r_idx   <= r_idx + IDX_W'(1);
                    if (w_last) begin
                        r_cout      <= w_c;
                        r_ovf       <= (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_f[3] != r_a[WIDTH-1]);
                        r_out_valid <= 1'b1;
                        r_state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign sum       = r_sum;
    assign cout      = r_cout;
    assign ovf       = r_ovf;
    assign busy      = r_busy;

endmodule

// File: tb/tb_cla_seq_adder.sv
// tb/tb_cla_seq_adder.sv - scoreboard bench for cla_seq_adder; subtract cases under CLA_SEQ_SUB_EN
module tb_cla_seq_adder;

    localparam int WIDTH = 16;
    localparam int NIB   = WIDTH / 4;

    typedef struct packed {
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             ovf;
    } exp_t;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             busy;

    exp_t sb_q[$];
    int   n_cmp;
    int   n_err;

    cla_seq_adder #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
`ifdef CLA_SEQ_SUB_EN
        .op        (op),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib,
                                   input logic icin, input logic iop);
        logic [WIDTH:0]   full;
        logic [WIDTH-1:0] bb;
        logic             c;
        exp_t             e;
        bb = ib;
        c  = icin;
`ifdef CLA_SEQ_SUB_EN
        if (iop) begin
            bb = ~ib;
            c  = 1'b1;
        end
`endif
        full   = {1'b0, ia} + {1'b0, bb} + {{WIDTH{1'b0}}, c};
        e.sum  = full[WIDTH-1:0];
        e.cout = full[WIDTH];
        e.ovf  = (ia[WIDTH-1] == bb[WIDTH-1]) && (full[WIDTH-1] != ia[WIDTH-1]);
        return e;
    endfunction

    // Called at a negedge; returns at a negedge with the block back in IDLE.
    task automatic run_op(input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib,
                          input logic icin, input logic iop, input int hold,
                          input bit mutate, input bit keep_valid);
        int   wait_cyc;
        int   lat;
        exp_t e;
        wait_cyc = 0;
        while (!in_ready && wait_cyc < 20) begin
            @(negedge clk);
            wait_cyc++;
        end
        check("in_ready_wait", {31'd0, in_ready}, 32'd1);
        a        = ia;
        b        = ib;
        cin      = icin;
        op       = iop;
        in_valid = 1'b1;
        @(posedge clk);
        sb_q.push_back(model(ia, ib, icin, iop));
        lat = 0;
        @(negedge clk);
        if (!keep_valid) in_valid = 1'b0;
        if (mutate) begin
            a   = WIDTH'($urandom);
            b   = WIDTH'($urandom);
            cin = ~icin;
            op  = ~iop;
        end
        check("busy_run", {31'd0, busy}, 32'd1);
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("latency", lat, NIB);
        check("sb_size", sb_q.size(), 1);
        e = sb_q.pop_front();
        for (int i = 0; i < hold; i++) begin
            check("hold_valid", {31'd0, out_valid}, 32'd1);
            check("hold_in_ready", {31'd0, in_ready}, 32'd0);
            check("hold_sum", {16'd0, sum}, {16'd0, e.sum});
            @(negedge clk);
        end
        check("sum", {16'd0, sum}, {16'd0, e.sum});
        check("cout", {31'd0, cout}, {31'd0, e.cout});
        check("ovf", {31'd0, ovf}, {31'd0, e.ovf});
        out_ready = 1'b1;
        @(negedge clk);
        check("idle_in_ready", {31'd0, in_ready}, 32'd1);
        check("idle_out_valid", {31'd0, out_valid}, 32'd0);
        check("idle_busy", {31'd0, busy}, 32'd0);
        out_ready = 1'b0;
        in_valid  = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
        check({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_sum"}, {16'd0, sum}, 32'd0);
        check({tag, "_cout"}, {31'd0, cout}, 32'd0);
        check({tag, "_ovf"}, {31'd0, ovf}, 32'd0);
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        op        = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        run_op(16'h1234, 16'h4321, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        run_op(16'h00FF, 16'h0001, 1'b1, 1'b0, 3, 1'b0, 1'b0);
        run_op(16'h0A0A, 16'h0505, 1'b1, 1'b0, 0, 1'b1, 1'b0);
        run_op(16'h8000, 16'h8000, 1'b0, 1'b0, 2, 1'b0, 1'b1);

        // Abort in the second RUN cycle; nothing may be reported for it.
        a        = 16'hABCD;
        b        = 16'h1111;
        cin      = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("abort");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("abort_no_valid", {31'd0, out_valid}, 32'd0);
        run_op(16'h0001, 16'h0001, 1'b0, 1'b0, 0, 1'b0, 1'b0);

        for (int k = 0; k < 6; k++) begin
            run_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'b0,
                   int'($urandom_range(0, 2)), 1'($urandom), 1'b0);
        end

`ifdef CLA_SEQ_SUB_EN
        run_op(16'h0005, 16'h0007, 1'b0, 1'b1, 0, 1'b0, 1'b0);
        run_op(16'h8000, 16'h0001, 1'b0, 1'b1, 0, 1'b0, 1'b0);
        run_op(16'h1234, 16'h1234, 1'b0, 1'b1, 1, 1'b1, 1'b0);
        for (int k = 0; k < 4; k++) begin
            run_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'($urandom),
                   0, 1'b0, 1'b0);
        end
`endif

        check("sb_drained", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
